// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, state encoding and frame helpers
package uart_pkg;

  // Bit-times per frame; shorter formats are padded with extra stop bits.
  localparam int FRAME_LEN = 11;

  // Clocks per bit-time for the standard rates at a 100 MHz system clock.
  localparam int BAUD_DIV_9600   = 10417;
  localparam int BAUD_DIV_19200  = 5208;
  localparam int BAUD_DIV_38400  = 2604;
  localparam int BAUD_DIV_57600  = 1736;
  localparam int BAUD_DIV_115200 = 868;
  localparam int BAUD_DIV_230400 = 434;
  localparam int BAUD_DIV_460800 = 217;
  localparam int BAUD_DIV_921600 = 109;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_e;

  // Parity over the transmitted data bits (7 or 8); ohel selects odd sense.
  function automatic logic parity_bit(input logic [7:0] data, input logic eight,
                                      input logic ohel);
    logic p;
    p = ^data[6:0];
    if (eight) p = p ^ data[7];
    return p ^ ohel;
  endfunction

  // Full frame, bit 0 first on the line: start, data, optional parity, stop fill.
  function automatic logic [FRAME_LEN-1:0] build_frame(input logic [7:0] data,
                                                       input logic eight,
                                                       input logic pen,
                                                       input logic ohel);
    logic [FRAME_LEN-1:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[7:1] = data[6:0];
    if (eight) begin
      f[8] = data[7];
      if (pen) f[9] = parity_bit(data, eight, ohel);
    end else begin
      if (pen) f[8] = parity_bit(data, eight, ohel);
    end
    return f;
  endfunction

endpackage

// File: rtl/uart_tx_engine_if.sv
// rtl/uart_tx_engine_if.sv - load/config/status bundle between TX control and the serial engine
interface uart_tx_engine_if #(
  parameter int BAUD_W = 19
) ();
  logic              load;
  logic [7:0]        data;
  logic              eight;
  logic              pen;
  logic              ohel;
  logic [BAUD_W-1:0] baud_k;
  logic              tx;
  logic              busy;
  logic              done;

  modport master (
    output load, data, eight, pen, ohel, baud_k,
    input  tx, busy, done
  );

  modport slave (
    input  load, data, eight, pen, ohel, baud_k,
    output tx, busy, done
  );
endinterface

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - loadable bit-time divisor with terminal-count pulse
module uart_bit_timer #(
  parameter int W = 19
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] div,
  input  logic         en,
  output logic         tc
);
  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt;
  logic [W-1:0] lim;

  // A divisor of zero behaves as one, so the limit saturates at zero.
  assign tc = en && (cnt == lim);

  // Capture the divisor on load, then count 0..lim and wrap while enabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      lim <= '0;
    end else if (load) begin
      cnt <= '0;
      lim <= (div == '0) ? '0 : div - ONE;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + ONE;
    end
  end
endmodule

// File: rtl/uart_tx_engine.sv
// rtl/uart_tx_engine.sv - UART transmit serialiser with start/parity/stop framing
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int BAUD_W = 19
) (
  input logic             clk,
  input logic             reset_n,
  uart_tx_engine_if.slave bus
);
  localparam logic [3:0] LAST_BIT = 4'(FRAME_LEN - 1);

  tx_state_e            state_q;
  tx_state_e            state_d;
  logic [FRAME_LEN-1:0] shreg;
  logic [3:0]           bit_cnt;
  logic                 busy_q;
  logic                 done_q;
  logic                 tc;
  logic                 accept;
  logic                 finish;
  logic                 sending;

  assign sending = (state_q == SEND);

  uart_bit_timer #(.W(BAUD_W)) u_bit_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (accept),
    .div     (bus.baud_k),
    .en      (sending),
    .tc      (tc)
  );

  // Next state: accept a load only when idle; leave after the last bit-time.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.load) begin
          accept  = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (tc && (bit_cnt == LAST_BIT)) begin
          finish  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Frame shifter and status flags; the line bit is the shifter's LSB so tx is a flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg   <= '1;
      bit_cnt <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      busy_q <= (state_d == SEND);
      done_q <= finish;
      if (accept) begin
        shreg   <= build_frame(bus.data, bus.eight, bus.pen, bus.ohel);
        bit_cnt <= '0;
      end else if (tc) begin
        shreg   <= {1'b1, shreg[FRAME_LEN-1:1]};
        bit_cnt <= finish ? 4'd0 : bit_cnt + 4'd1;
      end
    end
  end

  assign bus.tx   = shreg[0];
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_uart_tx_engine.sv
// tb/tb_uart_tx_engine.sv - self-checking bench for uart_tx_engine
module tb_uart_tx_engine;
  localparam int BAUD_W = 19;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  uart_tx_engine_if #(.BAUD_W(BAUD_W)) bus ();

  uart_tx_engine #(.BAUD_W(BAUD_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [7:0]        data;
    logic              eight;
    logic              pen;
    logic              ohel;
    logic [BAUD_W-1:0] k;
    logic [10:0]       bits;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference frame from the format rules: count ones for parity, place fields by position.
  function automatic logic [10:0] model_frame(input logic [7:0] d, input logic e,
                                             input logic p, input logic o);
    logic [10:0] f;
    int nb;
    int ones;
    f    = 11'h7FF;
    f[0] = 1'b0;
    nb   = e ? 8 : 7;
    ones = 0;
    for (int i = 0; i < nb; i++) begin
      f[1+i] = d[i];
      if (d[i]) ones++;
    end
    if (p) f[1+nb] = ((ones % 2) == 1) ^ o;
    return f;
  endfunction

  // Called at a negedge: present a frame, strobe load across one edge, then scramble inputs.
  task automatic start(input logic [7:0] d, input logic e, input logic p, input logic o,
                       input logic [BAUD_W-1:0] k);
    bus.data   = d;
    bus.eight  = e;
    bus.pen    = p;
    bus.ohel   = o;
    bus.baud_k = k;
    bus.load   = 1'b1;
    @(negedge clk);
    bus.load   = 1'b0;
    bus.data   = ~d;
    bus.eight  = ~e;
    bus.pen    = ~p;
    bus.ohel   = ~o;
    bus.baud_k = k + 3;
  endtask

  // Starting at the negedge of cycle T, check every cycle through the done cycle.
  task automatic check_frame(input logic [10:0] bits, input int k, input string nm,
                             input int inj);
    int kk;
    int len;
    kk  = (k == 0) ? 1 : k;
    len = 11 * kk;
    for (int n = 0; n <= len; n++) begin
      chk($sformatf("%s tx n=%0d", nm, n), 32'(bus.tx), (n < len) ? 32'(bits[n/kk]) : 32'd1);
      chk($sformatf("%s busy n=%0d", nm, n), 32'(bus.busy), (n < len) ? 32'd1 : 32'd0);
      chk($sformatf("%s done n=%0d", nm, n), 32'(bus.done), (n == len) ? 32'd1 : 32'd0);
      if (n == inj) begin
        bus.load   = 1'b1;
        bus.data   = 8'hFF;
        bus.baud_k = 10;
      end
      if (n == inj + 1) bus.load = 1'b0;
      if (n < len) @(negedge clk);
    end
  endtask

  task automatic idle_check(input int cycles, input string nm);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      chk($sformatf("%s idle tx %0d", nm, i), 32'(bus.tx), 32'd1);
      chk($sformatf("%s idle busy %0d", nm, i), 32'(bus.busy), 32'd0);
      chk($sformatf("%s idle done %0d", nm, i), 32'(bus.done), 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    logic [7:0]        rd;
    logic              re, rp, ro;
    logic [BAUD_W-1:0] rk;

    tbl[0] = '{8'h55, 1'b1, 1'b0, 1'b0, 19'd4, 11'b11010101010};
    tbl[1] = '{8'h07, 1'b1, 1'b1, 1'b0, 19'd4, 11'b11000001110};
    tbl[2] = '{8'hC1, 1'b0, 1'b1, 1'b1, 19'd2, 11'b11110000010};
    tbl[3] = '{8'h41, 1'b0, 1'b1, 1'b1, 19'd2, 11'b11110000010};
    tbl[4] = '{8'hA5, 1'b1, 1'b1, 1'b1, 19'd0, 11'b11101001010};
    tbl[5] = '{8'h7F, 1'b0, 1'b0, 1'b0, 19'd3, 11'b11111111110};

    reset_n    = 1'b0;
    bus.load   = 1'b0;
    bus.data   = 8'h00;
    bus.eight  = 1'b1;
    bus.pen    = 1'b0;
    bus.ohel   = 1'b0;
    bus.baud_k = 4;
    repeat (3) @(negedge clk);
    chk("reset tx", 32'(bus.tx), 32'd1);
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset done", 32'(bus.done), 32'd0);
    reset_n = 1'b1;
    idle_check(2, "post-reset");

    // Directed frames from the table.
    for (int i = 0; i < 6; i++) begin
      idle_check(2, $sformatf("tbl%0d", i));
      start(tbl[i].data, tbl[i].eight, tbl[i].pen, tbl[i].ohel, tbl[i].k);
      check_frame(tbl[i].bits, int'(tbl[i].k), $sformatf("tbl%0d", i), -1);
    end
    idle_check(3, "after-tbl");

    // Load and baud change while busy must not disturb the frame.
    start(8'h00, 1'b1, 1'b0, 1'b0, 4);
    check_frame(11'b11000000000, 4, "busy-load", 10);
    idle_check(6, "busy-load");

    // Asynchronous reset during bit 3 aborts silently.
    start(8'h00, 1'b1, 1'b0, 1'b0, 4);
    repeat (13) @(negedge clk);
    chk("pre-abort tx", 32'(bus.tx), 32'd0);
    chk("pre-abort busy", 32'(bus.busy), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("abort tx", 32'(bus.tx), 32'd1);
    chk("abort busy", 32'(bus.busy), 32'd0);
    chk("abort done", 32'(bus.done), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    idle_check(50, "after-abort");
    start(8'h07, 1'b1, 1'b1, 1'b0, 4);
    check_frame(11'b11000001110, 4, "post-abort", -1);

    // Back-to-back: second load lands in the done cycle.
    start(8'h55, 1'b1, 1'b0, 1'b0, 4);
    check_frame(11'b11010101010, 4, "b2b-a", -1);
    start(8'h41, 1'b0, 1'b1, 1'b1, 0);
    check_frame(11'b11110000010, 0, "b2b-b", -1);
    idle_check(2, "b2b");

    // Randomised frames against the reference model, mixing idle gaps and back-to-back.
    for (int r = 0; r < 24; r++) begin
      rd = 8'($urandom);
      re = 1'($urandom_range(0, 1));
      rp = 1'($urandom_range(0, 1));
      ro = 1'($urandom_range(0, 1));
      rk = BAUD_W'($urandom_range(0, 5));
      if ($urandom_range(0, 1) == 0) idle_check(int'($urandom_range(1, 3)), $sformatf("rnd%0d", r));
      start(rd, re, rp, ro, rk);
      check_frame(model_frame(rd, re, rp, ro), int'(rk), $sformatf("rnd%0d", r), -1);
    end
    idle_check(3, "final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_engine.md
Name: uart_tx_engine

Overview:
- Serial transmit engine of the UART TX path.
- Accepts a parallel byte on a one-cycle LOAD strobe and serialises it LSB-first with start, optional parity and stop bits at a programmable bit time.
- Emits a one-cycle DONE pulse at frame end. LOAD comes from the TXRDY set/reset flop's LOAD (reset) input; DONE drives that flop's set input.
- Sits between the processor-facing TX register write decode and the TX pin.

Parameters:
- BAUD_W, 19, width of the bit-time divisor input.
- FRAME_LEN, 11, bit-times per frame (fixed; shorter formats are padded with extra stop bits).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- load  in  1  one-cycle strobe: start a frame with `data`
- data  in  8  byte to transmit
- eight  in  1  1 = 8 data bits, 0 = 7 data bits (data[7] ignored)
- pen  in  1  parity enable
- ohel  in  1  parity sense: 1 = odd, 0 = even
- baud_k  in  BAUD_W  clocks per bit-time
- tx  out  1  serial line, idle high
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse at frame completion

Behaviour:
- Reset (async, reset_n=0):
  - tx=1, busy=0, done=0.
  - Shift register all ones; counters 0; state IDLE.
  - Applies immediately, including mid-frame; the aborted frame is not resumed or signalled.
- States: IDLE, SEND.
  - IDLE -> SEND on `load` sampled high at a clk edge.
  - SEND -> IDLE after FRAME_LEN bit-times.
- Load capture:
  - At the accepting edge, latch data, eight, pen, ohel and baud_k.
  - baud_k=0 is treated as 1.
  - Later changes to these inputs have no effect until the next load.
- Frame contents (LSB first), 11 positions:
  - start bit 0
  - data bits: 8 bits, or 7 bits when eight=0
  - parity bit, if pen=1
  - stop bits: remaining positions filled with 1
- Parity: XOR of the transmitted data bits (7 or 8), inverted when ohel=1.
- Timing, with T = first cycle after the accepting edge and K = latched baud_k:
  - tx drives frame bit i during cycles T+i*K .. T+(i+1)*K-1, for i=0..10.
  - busy=1 during T .. T+11*K-1.
  - done=1 for exactly cycle T+11*K. In that cycle busy=0 and tx=1.
- Bit-time counter:
  - Counts 0..K-1 and wraps.
  - Its terminal count shifts the register one position (fill value 1) and increments the bit counter (0..10).
  - At bit counter 10 with terminal count, the engine returns to IDLE.
- `load` while busy=1 is ignored (no restart, no corruption).
- `load` in the done cycle is accepted (busy=0). The next start bit begins the following cycle.
- tx is registered: no combinational path from inputs to tx.
- done and busy are registered outputs.

Decomposition:
- Shared package uart_pkg holds:
  - FRAME_LEN
  - state encoding constants (IDLE, SEND)
  - standard baud_k constants for the 100 MHz system clock (e.g. 115200 -> 868)
  - a parity function taking (data, eight, ohel)
- One natural sub-module: uart_bit_timer.
  - Loadable divisor; enable; terminal-count pulse output.
  - The receive engine will reuse it.

Test Plan:
- K=4, data=0x55, eight=1, pen=0, load at cycle 0:
  - tx sequence per 4-cycle bit = 0,1,0,1,0,1,0,1,0,1,1.
  - tx falls cycle 1; done high only at cycle 45; busy high cycles 1..44.
- K=4, data=0x07, eight=1, pen=1, ohel=0:
  - bits = 0,1,1,1,0,0,0,0,0,1(parity),1.
- K=2, data=0xC1, eight=0, pen=1, ohel=1:
  - bits = 0,1,0,0,0,0,0,1,1(parity),1,1.
  - data[7] has no effect: repeat with 0x41 and get an identical waveform.
- Busy and reconfiguration:
  - Pulse load with 0xFF at cycle 10 of a K=4 frame of 0x00: ignored; tx matches the 0x00 frame and done fires once.
  - Change baud_k to 10 mid-frame: bit widths stay 4.
- Reset mid-frame:
  - Assert reset_n=0 asynchronously during bit 3: tx=1, busy=0, done=0 with no clock edge.
  - After release, a new load produces a full correct frame with no done from the aborted one.
- Back-to-back and minimum divisor:
  - Load during the done cycle: next start bit begins the following cycle with no idle gap.
  - baud_k=0 yields 1-cycle bits, done at T+11.
